mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM stage of the 5-stage MIPS pipeline: takes the EX/MEM instruction (ALU result, store data, control), performs `lw`/`sw` over a request/grant data-memory port, and loads the MEM/WB pipeline register that feeds the writeback mux (ALU result vs. load data, chosen by MemtoReg). It stalls upstream stages while a memory access is outstanding. Non-memory instructions pass through in one cycle.

## Interface
- `DATA_W`, 32, data/word width
- `ADDR_W`, 32, byte address width
- `REG_W`, 5, register-number width
- `clk` in 1: sole clock, all state on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `ex_valid` in 1: EX/MEM holds a real instruction (0 = bubble)
- `ex_memread`, `ex_memwrite`, `ex_memtoreg`, `ex_regwrite` in 1 each: control from EX/MEM
- `ex_alu_out` in ADDR_W: ALU result or byte address
- `ex_store_data` in DATA_W: store data (forwarded Read_Data2)
- `ex_write_reg` in REG_W: destination register (after RegDst)
- `mem_stall` out 1: hold PC, IF/ID, ID/EX, EX/MEM this cycle
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out ADDR_W, `dmem_wdata` out DATA_W: memory request
- `dmem_gnt` in 1: request accepted this cycle
- `dmem_rvalid` in 1, `dmem_rdata` in DATA_W: load data return
- `wb_valid`, `wb_regwrite`, `wb_memtoreg` out 1 each; `wb_write_reg` out REG_W; `wb_alu_out` out ADDR_W; `wb_readdata` out DATA_W: MEM/WB register
- `mem_misalign` out 1: present only with `MEM_ALIGN_CHECK_EN`

## Operation
- FSM states IDLE, REQ, WAIT. Reset → IDLE.
- Mem op = `ex_valid & (ex_memread | ex_memwrite)`; both set is treated as a load.
- IDLE, no mem op: MEM/WB loads the EX/MEM fields on the next edge; `wb_valid=ex_valid`; `wb_regwrite=ex_regwrite & ex_valid`; `wb_readdata=0`; `mem_stall=0`.
- IDLE, mem op: the address, store data, we, write_reg, and control are latched into internal hold registers. Go to REQ. `mem_stall=1`. MEM/WB loads a bubble (`wb_valid=0`, `wb_regwrite=0`).
- REQ: `dmem_req=1`, driven from the hold registers. `dmem_addr` has bits [1:0] forced to 0.
  - On `dmem_gnt`, a store completes.
  - On `dmem_gnt`, a load goes to WAIT.
  - Without `dmem_gnt`, stay in REQ with the request stable.
- WAIT: `dmem_req=0`. On `dmem_rvalid`, capture `dmem_rdata` and complete. `dmem_rvalid` outside WAIT is ignored.
- Completion cycle: `mem_stall=0`, so upstream advances on the same edge.
  - MEM/WB loads the held instruction. `wb_valid=1`.
  - Load: `wb_readdata=dmem_rdata`.
  - Store: `wb_regwrite=0`, `wb_readdata=0`.
  - Go to IDLE.
- Otherwise `mem_stall=1` in REQ and WAIT. The stall signal is combinational from state, `ex_*`, `dmem_gnt`, and `dmem_rvalid`.
- Outstanding requests: one at most. No back-to-back overlap.

## Timing
- Reset values: all outputs 0 (MEM/WB fields, `dmem_*`, `mem_stall`, `mem_misalign`). Hold registers are 0.
- Reset mid-operation: on the next edge the FSM is in IDLE and `dmem_req=0`. A late `gnt`/`rvalid` is ignored.
- Latency from the EX/MEM edge to the MEM/WB update:
  - ALU op: 1 cycle.
  - Store: 2 cycles + grant wait.
  - Load: 2 cycles + grant wait + rvalid wait, with `rvalid` at least 1 cycle after `gnt`.
- `dmem_addr`, `dmem_we`, `dmem_wdata` are stable for the whole time `dmem_req=1`.
- Bubbles never raise `dmem_req` or `mem_stall`.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A mem op with `ex_alu_out[1:0]!=0` issues no request and does not stall.
  - The instruction passes to MEM/WB in 1 cycle with `wb_regwrite=0` and `wb_valid=1`.
  - `mem_misalign` pulses high for 1 cycle, coincident with that MEM/WB update.
- Undefined: no check. Low address bits are dropped (word access at `addr & ~3`). The `mem_misalign` port is absent.

## Structure
- Shared package `mips_pkg`: `mem_state_t` enum (IDLE/REQ/WAIT), `WORD_OFS_BITS=2`, and the default width constants.
- Sub-module `mem_wb_reg`: the MEM/WB register. It has load, bubble, and synchronous active-low reset inputs; the FSM drives it.

## Test plan
- **Reset:** hold `rst_n=0` 2 cycles with `dmem_gnt=dmem_rvalid=1`. Required: all outputs 0, `dmem_req=0`.
- **ALU op:** `ex_valid=1`, `ex_regwrite=1`, `ex_alu_out=0x0000_1234`, `ex_write_reg=5`. Required next cycle: `wb_valid=1`, `wb_alu_out=0x1234`, `wb_write_reg=5`; `mem_stall=0` throughout.
- **Store, grant delayed:** `sw` with addr 0x100, data 0xDEADBEEF, `dmem_gnt` on the 3rd REQ cycle. Required:
  - `dmem_req` high 3 cycles with `dmem_we=1` and `dmem_addr=0x100`.
  - `mem_stall` high until the grant cycle.
  - Then `wb_valid=1`, `wb_regwrite=0`.
- **Load:** `lw` to r8 from 0x200, immediate `gnt`, `rvalid` 2 cycles later with 0xCAFEF00D. Required 1 cycle after `rvalid`: `wb_readdata=0xCAFEF00D`, `wb_memtoreg=1`, `wb_write_reg=8`, `wb_regwrite=1`.
- **Reset in WAIT:** assert `rst_n=0` while in WAIT, then send a stray `rvalid` with 0x1111_1111. Required: FSM in IDLE, `wb_valid=0`, `wb_readdata=0`.
- **Misaligned `lw` at 0x102:**
  - With `MEM_ALIGN_CHECK_EN`: no `dmem_req`, `mem_misalign` 1-cycle pulse, `wb_regwrite=0`.
  - Without: `dmem_addr=0x100`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline MEM stage: FSM state type,
// word-offset width and default bus widths.
package mips_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 32;
  localparam int REG_W_DEF     = 5;
  localparam int WORD_OFS_BITS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Bubble has priority over load; reset clears
// every field so the writeback stage sees a harmless empty slot.
module mem_wb_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic              valid_d,
  input  logic              regwrite_d,
  input  logic              memtoreg_d,
  input  logic [REG_W-1:0]  write_reg_d,
  input  logic [ADDR_W-1:0] alu_out_d,
  input  logic [DATA_W-1:0] readdata_d,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [ADDR_W-1:0] wb_alu_out,
  output logic [DATA_W-1:0] wb_readdata
);

  // Register update: reset, insert bubble, or capture the next instruction.
  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_write_reg <= '0;
      wb_alu_out   <= '0;
      wb_readdata  <= '0;
    end else if (load) begin
      wb_valid     <= valid_d;
      wb_regwrite  <= regwrite_d;
      wb_memtoreg  <= memtoreg_d;
      wb_write_reg <= write_reg_d;
      wb_alu_out   <= alu_out_d;
      wb_readdata  <= readdata_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: issues lw/sw over a req/gnt data
// port, stalls upstream while an access is outstanding and feeds MEM/WB.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned mem ops are
// retired without a request and flagged on mem_misalign).
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_regwrite,
  input  logic [ADDR_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_write_reg,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [ADDR_W-1:0] wb_alu_out,
  output logic [DATA_W-1:0] wb_readdata
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              mem_misalign
`endif
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;

  logic              mem_op, misalign, issue, done;
  logic              wb_load, wb_bubble;
  logic              nv_valid, nv_regwrite, nv_memtoreg;
  logic [REG_W-1:0]  nv_wreg;
  logic [ADDR_W-1:0] nv_alu;
  logic [DATA_W-1:0] nv_rdata;

  // Load+store together is treated as a load.
  assign mem_op = ex_valid & (ex_memread | ex_memwrite);
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & (ex_alu_out[WORD_OFS_BITS-1:0] != '0);
`else
  assign misalign = 1'b0;
`endif
  assign issue = mem_op & ~misalign;

  // Request port is driven purely from the hold registers so it stays
  // stable while waiting for a grant; the word offset is dropped.
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[ADDR_W-1:WORD_OFS_BITS], {WORD_OFS_BITS{1'b0}}};
  assign dmem_wdata = wdata_q;

  // Next-state, stall and MEM/WB source selection.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    wreg_d      = wreg_q;
    regwrite_d  = regwrite_q;
    memtoreg_d  = memtoreg_q;
    mem_stall   = 1'b0;
    done        = 1'b0;
    wb_load     = 1'b0;
    wb_bubble   = 1'b0;
    nv_valid    = ex_valid;
    nv_regwrite = ex_regwrite & ex_valid & ~misalign;
    nv_memtoreg = ex_memtoreg;
    nv_wreg     = ex_write_reg;
    nv_alu      = ex_alu_out;
    nv_rdata    = '0;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          addr_d     = ex_alu_out;
          wdata_d    = ex_store_data;
          we_d       = ex_memwrite & ~ex_memread;
          wreg_d     = ex_write_reg;
          regwrite_d = ex_regwrite;
          memtoreg_d = ex_memtoreg;
          state_d    = REQ;
          mem_stall  = 1'b1;
          wb_bubble  = 1'b1;
        end else begin
          wb_load = 1'b1;
        end
      end
      REQ: begin
        if (dmem_gnt && we_q) begin
          done = 1'b1;
        end else begin
          if (dmem_gnt) state_d = WAIT;
          mem_stall = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          done     = 1'b1;
          nv_rdata = dmem_rdata;
        end else begin
          mem_stall = 1'b1;
          wb_bubble = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        wb_bubble = 1'b1;
      end
    endcase
    if (done) begin
      state_d     = IDLE;
      wb_load     = 1'b1;
      nv_valid    = 1'b1;
      nv_regwrite = regwrite_q & ~we_q;
      nv_memtoreg = memtoreg_q;
      nv_wreg     = wreg_q;
      nv_alu      = addr_q;
    end
  end

  // FSM state and hold registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      wreg_q     <= wreg_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q;
  // Flag pulse lines up with the MEM/WB update of the misaligned op.
  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= (state_q == IDLE) & misalign;
  end
  assign mem_misalign = misalign_q;
`endif

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W)
  ) u_mem_wb (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (wb_load),
    .bubble       (wb_bubble),
    .valid_d      (nv_valid),
    .regwrite_d   (nv_regwrite),
    .memtoreg_d   (nv_memtoreg),
    .write_reg_d  (nv_wreg),
    .alu_out_d    (nv_alu),
    .readdata_d   (nv_rdata),
    .wb_valid     (wb_valid),
    .wb_regwrite  (wb_regwrite),
    .wb_memtoreg  (wb_memtoreg),
    .wb_write_reg (wb_write_reg),
    .wb_alu_out   (wb_alu_out),
    .wb_readdata  (wb_readdata)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed test-plan items, then randomized
// instruction stream against an in-order instruction/memory model.
module tb_mem_access_stage;

  logic        clk, rst_n;
  logic        ex_valid, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
  logic [31:0] ex_alu_out, ex_store_data;
  logic [4:0]  ex_write_reg;
  logic        mem_stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_regwrite, wb_memtoreg;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_alu_out, wb_readdata;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_misalign;
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_write_reg(wb_write_reg), .wb_alu_out(wb_alu_out), .wb_readdata(wb_readdata)
`ifdef MEM_ALIGN_CHECK_EN
    , .mem_misalign(mem_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected MEM/WB contents of one retired instruction.
  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic [4:0]  wreg;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem   [16];
  logic [31:0] slave_mem [16];

  logic        stall_s, pend, real_rv, stuck;
  int          pend_dly, stall_run;
  logic [31:0] pend_data;
  logic        prev_req, prev_gnt, prev_we;
  logic [31:0] prev_addr, prev_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; ex_memread = 0; ex_memwrite = 0; ex_memtoreg = 0; ex_regwrite = 0;
    ex_alu_out = 0; ex_store_data = 0; ex_write_reg = 0;
  endtask

  task automatic ex_set(input logic rd, input logic wr, input logic m2r, input logic rw,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
    ex_valid = 1; ex_memread = rd; ex_memwrite = wr; ex_memtoreg = m2r; ex_regwrite = rw;
    ex_alu_out = a; ex_store_data = d; ex_write_reg = r;
  endtask

  // New EX/MEM content; real instructions are retired by the model in order.
  task automatic drive_new();
    int k;
    exp_t e;
    logic mop;
    logic [3:0] idx;
    k = $urandom_range(0, 9);
    ex_memread    = 0;
    ex_memwrite   = 0;
    ex_memtoreg   = 1'($urandom_range(0, 1));
    ex_regwrite   = 1'($urandom_range(0, 1));
    ex_write_reg  = 5'($urandom);
    ex_store_data = $urandom;
    ex_alu_out    = $urandom;
    ex_valid      = (k >= 2);
    if (k < 2) begin
      ex_memread  = 1'($urandom_range(0, 1));
      ex_memwrite = 1'($urandom_range(0, 1));
    end else if (k >= 5 && k <= 7) begin
      ex_memread  = 1;
      ex_memwrite = (k == 7);
      ex_alu_out  = 32'($urandom_range(0, 63));
    end else if (k >= 8) begin
      ex_memwrite = 1;
      ex_alu_out  = 32'($urandom_range(0, 63));
    end
    if (ex_valid) begin
      mop        = ex_memread | ex_memwrite;
      idx        = ex_alu_out[5:2];
      e.mis      = ALIGN_EN && mop && (ex_alu_out[1:0] != 2'b00);
      e.memtoreg = ex_memtoreg;
      e.wreg     = ex_write_reg;
      e.alu      = ex_alu_out;
      e.regwrite = ex_regwrite && !e.mis && !(mop && !ex_memread);
      e.rdata    = (mop && ex_memread && !e.mis) ? ref_mem[idx] : 32'h0;
      if (mop && !ex_memread && !e.mis) ref_mem[idx] = ex_store_data;
      exp_q.push_back(e);
    end
  endtask

  // One randomized cycle: drive, sample on the falling edge, update slave.
  task automatic run_cycle(input bit allow_new);
    exp_t e;
    logic [3:0] idx;
    tick();
    if (!stall_s) begin
      if (allow_new) drive_new();
      else ex_idle();
    end
    dmem_gnt = ($urandom_range(0, 9) < 4);
    real_rv  = 0;
    if (pend) begin
      if (pend_dly == 0) begin
        dmem_rvalid = ($urandom_range(0, 1) == 1);
        real_rv     = dmem_rvalid;
        dmem_rdata  = pend_data;
      end else begin
        dmem_rvalid = 0;
        pend_dly--;
      end
    end else begin
      dmem_rvalid = ($urandom_range(0, 9) < 2);
      dmem_rdata  = $urandom;
    end
    @(negedge clk);
    if (dmem_req) begin
      chk("addr_word_aligned", 80'(dmem_addr[1:0]), 80'(0));
      chk("addr_high_bits", 80'(dmem_addr[31:6]), 80'(0));
    end
    if (prev_req && !prev_gnt)
      chk("req_stable", 80'({dmem_req, dmem_we, dmem_addr, dmem_wdata}),
          80'({1'b1, prev_we, prev_addr, prev_wdata}));
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 80'(1), 80'(0));
      end else begin
        e = exp_q.pop_front();
        chk("wb_fields", 80'({wb_regwrite, wb_memtoreg, wb_write_reg, wb_alu_out, wb_readdata}),
            80'({e.regwrite, e.memtoreg, e.wreg, e.alu, e.rdata}));
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign_flag", 80'(mem_misalign), 80'(e.mis));
`endif
      end
    end else begin
      chk("bubble_regwrite", 80'(wb_regwrite), 80'(0));
    end
    prev_req = dmem_req; prev_gnt = dmem_gnt; prev_we = dmem_we;
    prev_addr = dmem_addr; prev_wdata = dmem_wdata;
    stall_s = mem_stall;
    if (dmem_req && dmem_gnt) begin
      idx = dmem_addr[5:2];
      if (dmem_we) slave_mem[idx] = dmem_wdata;
      else begin
        pend      = 1;
        pend_data = slave_mem[idx];
        pend_dly  = $urandom_range(0, 2);
      end
    end
    if (real_rv) pend = 0;
    stall_run = mem_stall ? stall_run + 1 : 0;
    if (stall_run > 80) begin
      chk("stall_timeout", 80'(stall_run), 80'(0));
      stuck = 1;
    end
  endtask

  initial begin
    // Reset with grant and rvalid held high.
    rst_n = 0; ex_idle();
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h5A5A_5A5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_wb", 80'({wb_valid, wb_regwrite, wb_memtoreg, wb_write_reg, wb_alu_out, wb_readdata}), 80'(0));
    chk("reset_dmem", 80'({dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_stall}), 80'(0));
`ifdef MEM_ALIGN_CHECK_EN
    chk("reset_misalign", 80'(mem_misalign), 80'(0));
`endif

    // ALU op passes in one cycle.
    tick(); rst_n = 1; dmem_gnt = 0; dmem_rvalid = 0;
    ex_set(0, 0, 0, 1, 32'h0000_1234, 32'h0, 5'd5);
    @(negedge clk);
    chk("alu_stall", 80'({mem_stall, dmem_req}), 80'(0));
    tick(); ex_idle();
    @(negedge clk);
    chk("alu_wb", 80'({wb_valid, wb_regwrite, wb_write_reg, wb_alu_out}), 80'({1'b1, 1'b1, 5'd5, 32'h1234}));
    chk("alu_stall2", 80'(mem_stall), 80'(0));

    // Store with grant on the 3rd request cycle.
    tick(); ex_set(0, 1, 0, 1, 32'h100, 32'hDEAD_BEEF, 5'd7);
    @(negedge clk);
    chk("sw_idle", 80'({mem_stall, dmem_req}), 80'(2'b10));
    for (int i = 0; i < 3; i++) begin
      tick(); dmem_gnt = (i == 2);
      @(negedge clk);
      chk("sw_req", 80'({dmem_req, dmem_we, dmem_addr, dmem_wdata}), 80'({1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF}));
      chk("sw_stall", 80'(mem_stall), 80'(i != 2));
    end
    tick(); dmem_gnt = 0; ex_idle();
    @(negedge clk);
    chk("sw_wb", 80'({wb_valid, wb_regwrite, wb_readdata, dmem_req}), 80'({1'b1, 1'b0, 32'h0, 1'b0}));

    // Load, immediate grant, rvalid two cycles later.
    tick(); ex_set(1, 0, 1, 1, 32'h200, 32'h0, 5'd8);
    @(negedge clk);
    chk("lw_stall0", 80'(mem_stall), 80'(1));
    tick(); dmem_gnt = 1;
    @(negedge clk);
    chk("lw_req", 80'({dmem_req, dmem_we, dmem_addr}), 80'({1'b1, 1'b0, 32'h200}));
    tick(); dmem_gnt = 0;
    @(negedge clk);
    chk("lw_wait", 80'({dmem_req, mem_stall}), 80'(2'b01));
    tick(); dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("lw_done_stall", 80'(mem_stall), 80'(0));
    tick(); dmem_rvalid = 0; ex_idle();
    @(negedge clk);
    chk("lw_wb", 80'({wb_valid, wb_regwrite, wb_memtoreg, wb_write_reg, wb_readdata}),
        80'({1'b1, 1'b1, 1'b1, 5'd8, 32'hCAFE_F00D}));

    // Reset while waiting for read data, then a stray rvalid.
    tick(); ex_set(1, 0, 1, 1, 32'h200, 32'h0, 5'd8);
    tick(); dmem_gnt = 1;
    tick(); dmem_gnt = 0; rst_n = 0; ex_idle();
    @(negedge clk);
    chk("rstwait_in_wait", 80'({dmem_req, mem_stall}), 80'(2'b01));
    tick(); rst_n = 1; dmem_rvalid = 1; dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("rstwait_idle", 80'({dmem_req, mem_stall}), 80'(0));
    tick(); dmem_rvalid = 0;
    @(negedge clk);
    chk("rstwait_wb", 80'({wb_valid, wb_readdata}), 80'(0));

    // Misaligned load at 0x102.
`ifdef MEM_ALIGN_CHECK_EN
    tick(); ex_set(1, 0, 1, 1, 32'h102, 32'h0, 5'd3);
    @(negedge clk);
    chk("mis_nostall", 80'({mem_stall, dmem_req}), 80'(0));
    tick(); ex_idle();
    @(negedge clk);
    chk("mis_pulse", 80'({mem_misalign, wb_valid, wb_regwrite, dmem_req}), 80'(4'b1100));
    tick();
    @(negedge clk);
    chk("mis_pulse_end", 80'(mem_misalign), 80'(0));
`else
    tick(); ex_set(1, 0, 1, 1, 32'h102, 32'h0, 5'd3);
    tick(); dmem_gnt = 1;
    @(negedge clk);
    chk("mis_addr", 80'({dmem_req, dmem_addr}), 80'({1'b1, 32'h100}));
    tick(); dmem_gnt = 0;
    tick(); dmem_rvalid = 1; dmem_rdata = 32'h55;
    tick(); dmem_rvalid = 0; ex_idle();
    @(negedge clk);
    chk("mis_wb", 80'({wb_valid, wb_alu_out, wb_readdata}), 80'({1'b1, 32'h102, 32'h55}));
`endif

    // Randomized stream against the model.
    tick(); rst_n = 0; ex_idle(); dmem_gnt = 0; dmem_rvalid = 0;
    tick(); rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 0;
      slave_mem[i] = 0;
    end
    exp_q.delete();
    stall_s = 0; pend = 0; pend_dly = 0; stall_run = 0; stuck = 0; real_rv = 0;
    prev_req = 0; prev_gnt = 0; prev_we = 0; prev_addr = 0; prev_wdata = 0;
    for (int c = 0; c < 3000 && !stuck; c++) run_cycle(1'b1);
    for (int c = 0; c < 300 && !stuck && exp_q.size() != 0; c++) run_cycle(1'b0);
    chk("drain_empty", 80'(exp_q.size()), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
